cache_line_fill: RTL and testbench

- Refill stage directly upstream of the cache data array.
- On a miss, accepts a fill command (line address, set index, way/chan), requests the line from the memory bus and collects BEATS narrow read beats into one line buffer.
- Performs a single-cycle write of the full line into the data memory at {chan,index}, then reports completion or error to the cache controller.

---
 rtl/cache_line_fill.sv | 147 ++++++++++++++
 tb/tb_cache_line_fill.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - cache line refill: fetch BEATS memory beats, write one full line into the data array
//
// Ports:
//   clk, rsta                  clock, asynchronous active-high reset
//   fill_req/addr/index/chan   fill command from the cache controller (sampled in IDLE only)
//   fill_busy/done/error       status back to the controller (done/error are one-cycle pulses)
//   mem_req_valid/ready/addr   read request to the memory bus
//   mem_rvalid/rdata/rerr      read beats from the memory bus, mem_rready accepts them
//   dm_index/chan/data/wr      single-cycle full-line write into the data memory
module cache_line_fill #(
    parameter int INDEX_WIDTH = 4,
    parameter int CHAN_WIDTH  = 3,
    parameter int DATA_WIDTH  = 128,
    parameter int BEAT_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rsta,
    input  logic                   fill_req,
    input  logic [ADDR_WIDTH-1:0]  fill_addr,
    input  logic [INDEX_WIDTH-1:0] fill_index,
    input  logic [CHAN_WIDTH-1:0]  fill_chan,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   fill_error,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rvalid,
    input  logic [BEAT_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_rerr,
    output logic                   mem_rready,
    output logic [INDEX_WIDTH-1:0] dm_index,
    output logic [CHAN_WIDTH-1:0]  dm_chan,
    output logic [DATA_WIDTH-1:0]  dm_data,
    output logic                   dm_wr
);

    localparam int BEATS     = DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 beat_ok;
    logic                 beat_err;
    logic                 last_beat;

    // Beats are only looked at in BEAT; a stray rvalid elsewhere has no effect.
    assign beat_ok   = (state == BEAT) && mem_rvalid && !mem_rerr;
    assign beat_err  = (state == BEAT) && mem_rvalid && mem_rerr;
    assign last_beat = (cnt == CNT_WIDTH'(BEATS - 1));

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fill_req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = BEAT;
                end
            end
            BEAT: begin
                if (beat_err) begin
                    state_next = IDLE;
                end else if (beat_ok && last_beat) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake strobes are pure decodes of the state register, so none of
    // them combinationally depends on an input.
    assign fill_busy     = (state != IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_rready    = (state == BEAT);
    assign dm_wr         = (state == WRITE);

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            mem_req_addr <= '0;
            dm_index     <= '0;
            dm_chan      <= '0;
            dm_data      <= '0;
            cnt          <= '0;
            fill_done    <= 1'b0;
            fill_error   <= 1'b0;
        end else begin
            fill_done  <= 1'b0;
            fill_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_req) begin
                        mem_req_addr <= fill_addr;
                        dm_index     <= fill_index;
                        dm_chan      <= fill_chan;
                        // Cleared so an aborted fill can never leak into the next line.
                        dm_data      <= '0;
                        cnt          <= '0;
                    end
                end
                BEAT: begin
                    if (beat_ok) begin
                        dm_data[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                        cnt <= last_beat ? '0 : cnt + CNT_WIDTH'(1);
                    end
                    // Pulse lands in the first IDLE cycle after the error beat.
                    if (beat_err) begin
                        fill_error <= 1'b1;
                    end
                end
                WRITE: begin
                    fill_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - directed scoreboard bench for cache_line_fill
module tb_cache_line_fill;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int CW = 3;
    localparam int DW = 128;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rsta;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic [IW-1:0] fill_index;
    logic [CW-1:0] fill_chan;
    logic          fill_busy;
    logic          fill_done;
    logic          fill_error;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rvalid;
    logic [BW-1:0] mem_rdata;
    logic          mem_rerr;
    logic          mem_rready;
    logic [IW-1:0] dm_index;
    logic [CW-1:0] dm_chan;
    logic [DW-1:0] dm_data;
    logic          dm_wr;

    cache_line_fill #(
        .INDEX_WIDTH(IW), .CHAN_WIDTH(CW), .DATA_WIDTH(DW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rsta(rsta),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_index(fill_index), .fill_chan(fill_chan),
        .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr), .mem_rready(mem_rready),
        .dm_index(dm_index), .dm_chan(dm_chan), .dm_data(dm_data), .dm_wr(dm_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int err_count = 0;
    int last_wr_cyc = -1;
    logic [BW-1:0] beats [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and protocol monitor.
    always @(negedge clk) begin
        if (!rsta) begin
            if (dm_wr) begin
                wr_count++;
                last_wr_cyc = cyc;
                check("sb_has_entry", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("dm_index", dm_index, mon_e.idx);
                    check("dm_chan", dm_chan, mon_e.ch);
                    check("dm_data", dm_data, mon_e.data);
                end
            end
            if (mem_rvalid) check("rvalid_outside_beat", mem_rready, 1);
            if (fill_done) done_count++;
            if (fill_error) err_count++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, fill_busy, 0);
        check({tag, "_done"}, fill_done, 0);
        check({tag, "_error"}, fill_error, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_rready"}, mem_rready, 0);
        check({tag, "_dm_wr"}, dm_wr, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_dm_index"}, dm_index, 0);
        check({tag, "_dm_chan"}, dm_chan, 0);
        check({tag, "_dm_data"}, dm_data, 0);
    endtask

    // Call at a negedge; returns #1 after the accepting edge with that cycle number.
    task automatic start_fill(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic [CW-1:0] c,
                              output int acc);
        fill_req = 1'b1;
        fill_addr = a;
        fill_index = i;
        fill_chan = c;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        acc = cyc;
    endtask

    // Memory-side model: request stall, optional idle gap before beat gap_at,
    // error on beat err_at, busy-drop pulse on beat busy_at, reset after beat rst_at.
    task automatic mem_serve(input logic [AW-1:0] a, input int stall, input int gap_at,
                             input int err_at, input int busy_at, input int rst_at);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, a);
            if (i == stall) mem_req_ready = 1'b1;
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) @(negedge clk);
            @(negedge clk);
            check("rready", mem_rready, 1);
            mem_rvalid = 1'b1;
            mem_rdata = beats[k];
            mem_rerr = (k == err_at);
            if (k == busy_at) begin
                fill_req = 1'b1;
                fill_index = 4'd9;
                fill_chan = 3'd0;
                fill_addr = 32'hdead_0000;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rerr = 1'b0;
            fill_req = 1'b0;
            if (k == err_at) break;
            if (k == rst_at) begin
                #2 rsta = 1'b1;
                #1 check_all_zero("rst_mid");
                return;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fill_done && n < 40);
        check({tag, "_done_seen"}, fill_done, 1);
        check({tag, "_done_cyc"}, cyc, exp_cyc);
        check({tag, "_wr_cyc"}, last_wr_cyc, exp_cyc - 1);
        check({tag, "_busy_at_done"}, fill_busy, 0);
    endtask

    task automatic set_beats(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                             input logic [BW-1:0] b2, input logic [BW-1:0] b3);
        beats[0] = b0;
        beats[1] = b1;
        beats[2] = b2;
        beats[3] = b3;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, a2, wc, dc, ec;
        logic [DW-1:0] d1;
        d1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rsta = 1'b1;
        fill_req = 1'b0;
        fill_addr = '0;
        fill_index = '0;
        fill_chan = '0;
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        mem_rerr = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rsta = 1'b0;
        @(negedge clk);

        // 1: basic fill, best-case latency
        set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        sb.push_back('{idx: 4'd5, ch: 3'd3, data: d1});
        start_fill(32'h0000_1040, 4'd5, 3'd3, a);
        mem_serve(32'h0000_1040, 0, -1, -1, -1, -1);
        wait_done("t1", a + 6);

        // 2: three-cycle request stall plus one gap between beats
        sb.push_back('{idx: 4'd5, ch: 3'd3, data: d1});
        start_fill(32'h0000_1040, 4'd5, 3'd3, a);
        mem_serve(32'h0000_1040, 3, 2, -1, -1, -1);
        wait_done("t2", a + 6 + 4);

        // 3: bus error on the second beat, then a clean fill
        set_beats(32'hdeadbeef, 32'hbad0bad0, 32'hcafef00d, 32'h01234567);
        start_fill(32'h0000_2000, 4'd7, 3'd2, a);
        wc = wr_count;
        ec = err_count;
        mem_serve(32'h0000_2000, 0, -1, 1, -1, -1);
        @(negedge clk);
        check("t3_error_pulse", fill_error, 1);
        check("t3_busy", fill_busy, 0);
        @(negedge clk);
        check("t3_error_once", fill_error, 0);
        #1;
        check("t3_no_wr", wr_count, wc);
        check("t3_err_count", err_count, ec + 1);
        set_beats(32'ha0a0a0a0, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3);
        sb.push_back('{idx: 4'd0, ch: 3'd7,
                       data: {32'ha3a3a3a3, 32'ha2a2a2a2, 32'ha1a1a1a1, 32'ha0a0a0a0}});
        @(negedge clk);
        start_fill(32'h0000_3000, 4'd0, 3'd7, a);
        mem_serve(32'h0000_3000, 0, -1, -1, -1, -1);
        wait_done("t3b", a + 6);

        // 4: fill_req during BEAT is dropped
        set_beats(32'h0badf00d, 32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f);
        sb.push_back('{idx: 4'd4, ch: 3'd5,
                       data: {32'h0f0f0f0f, 32'h9abcdef0, 32'h12345678, 32'h0badf00d}});
        @(negedge clk);
        start_fill(32'h0000_4000, 4'd4, 3'd5, a);
        wc = wr_count;
        dc = done_count;
        mem_serve(32'h0000_4000, 0, -1, -1, 1, -1);
        wait_done("t4", a + 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_second_req", mem_req_valid, 0);
        end
        #1;
        check("t4_one_done", done_count, dc + 1);
        check("t4_one_wr", wr_count, wc + 1);

        // 5: back-to-back fills, second accepted in the fill_done cycle
        set_beats(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004);
        sb.push_back('{idx: 4'd2, ch: 3'd1,
                       data: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}});
        sb.push_back('{idx: 4'd12, ch: 3'd6,
                       data: {32'hf0000004, 32'hf0000003, 32'hf0000002, 32'hf0000001}});
        @(negedge clk);
        start_fill(32'h0000_5000, 4'd2, 3'd1, a);
        mem_serve(32'h0000_5000, 0, -1, -1, -1, -1);
        wait_done("t5a", a + 6);
        start_fill(32'h0000_6000, 4'd12, 3'd6, a2);
        check("t5_b2b_accept", a2, a + 7);
        set_beats(32'hf0000001, 32'hf0000002, 32'hf0000003, 32'hf0000004);
        mem_serve(32'h0000_6000, 0, -1, -1, -1, -1);
        wait_done("t5b", a2 + 6);

        // 6: reset after the first beat, then test 1 again
        set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        @(negedge clk);
        start_fill(32'h0000_1040, 4'd5, 3'd3, a);
        wc = wr_count;
        dc = done_count;
        ec = err_count;
        mem_serve(32'h0000_1040, 0, -1, -1, -1, 0);
        repeat (2) @(negedge clk);
        rsta = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t6_no_wr", wr_count, wc);
        check("t6_no_done", done_count, dc);
        check("t6_no_err", err_count, ec);
        check("t6_idle", fill_busy, 0);
        sb.push_back('{idx: 4'd5, ch: 3'd3, data: d1});
        @(negedge clk);
        start_fill(32'h0000_1040, 4'd5, 3'd3, a);
        mem_serve(32'h0000_1040, 0, -1, -1, -1, -1);
        wait_done("t6", a + 6);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
